// File: rtl/fbuf_write_arbiter.sv
// fbuf_write_arbiter
// Shares the single framebuffer BRAM write port between two requesters:
// req0 (GPU command handler, single-pixel writes) and req1 (fill/blit
// engine, multi-beat bursts). Arbitration is round-robin with burst locking
// and a per-grant beat cap. The BRAM write port is registered (1-cycle
// latency). Beats whose address is outside the framebuffer are accepted,
// never written, and flagged on err_oob.
//
// Optional build macro FBUF_ARB_STATS_EN adds saturating statistics
// counters (accepted beats per requester, direct owner switches) with a
// stat_clr input. Without the macro those ports do not exist.
module fbuf_write_arbiter #(
    parameter int unsigned FBUF_ADDR_WIDTH = 19,
    parameter int unsigned FBUF_DATA_WIDTH = 8,
    parameter int unsigned FBUF_DEPTH      = 307200,
    parameter int unsigned MAX_BURST       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       r0_valid,
    output logic                       r0_ready,
    input  logic                       r0_last,
    input  logic [FBUF_ADDR_WIDTH-1:0] r0_addr,
    input  logic [FBUF_DATA_WIDTH-1:0] r0_data,
    input  logic                       r1_valid,
    output logic                       r1_ready,
    input  logic                       r1_last,
    input  logic [FBUF_ADDR_WIDTH-1:0] r1_addr,
    input  logic [FBUF_DATA_WIDTH-1:0] r1_data,
    output logic                       fbuf_en_wr,
    output logic                       fbuf_wrea,
    output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
    output logic [FBUF_DATA_WIDTH-1:0] fbuf_data,
    output logic [1:0]                 grant,
    output logic                       err_oob,
`ifdef FBUF_ARB_STATS_EN
    input  logic                       stat_clr,
    output logic [31:0]                stat_beats0,
    output logic [31:0]                stat_beats1,
    output logic [31:0]                stat_switches,
`endif
    output logic                       busy
);

    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    // Counter is sized for the largest legal cap (256 beats -> 0..255).
    localparam logic [7:0] CAP_LAST = 8'(MAX_BURST - 1);

    state_t                     r_state;
    logic                       r_prio;      // 0: req0 wins a tie, 1: req1 wins
    logic [7:0]                 r_beat_cnt;
    logic                       r_wr_en;
    logic [FBUF_ADDR_WIDTH-1:0] r_wr_addr;
    logic [FBUF_DATA_WIDTH-1:0] r_wr_data;
    logic                       r_err_oob;

    logic                       w_acc0;
    logic                       w_acc1;
    logic                       w_acc;
    logic                       w_last;
    logic [FBUF_ADDR_WIDTH-1:0] w_addr;
    logic [FBUF_DATA_WIDTH-1:0] w_data;
    logic                       w_oob;
    logic                       w_cap;
    logic                       w_release;
    logic                       w_other_valid;
    state_t                     w_other_state;

    // Ready is a pure decode of the registered state, never of valid.
    assign r0_ready = (r_state == GNT0);
    assign r1_ready = (r_state == GNT1);

    assign w_acc0 = r0_valid && (r_state == GNT0);
    assign w_acc1 = r1_valid && (r_state == GNT1);
    assign w_acc  = w_acc0 || w_acc1;

    // Beat fields from whichever requester currently owns the port.
    assign w_last = w_acc1 ? r1_last : r0_last;
    assign w_addr = (r_state == GNT1) ? r1_addr : r0_addr;
    assign w_data = (r_state == GNT1) ? r1_data : r0_data;

    assign w_oob     = (32'(w_addr) >= FBUF_DEPTH);
    assign w_cap     = (r_beat_cnt == CAP_LAST);
    assign w_release = w_acc && (w_last || w_cap);

    assign w_other_valid = (r_state == GNT0) ? r1_valid : r0_valid;
    assign w_other_state = (r_state == GNT0) ? GNT1 : GNT0;

    assign grant      = r_state;
    assign busy       = (r_state != IDLE);
    assign fbuf_en_wr = r_wr_en;
    assign fbuf_wrea  = r_wr_en;
    assign fbuf_addr  = r_wr_addr;
    assign fbuf_data  = r_wr_data;
    assign err_oob    = r_err_oob;

    // Arbitration FSM: owner selection, beat counting, round-robin pointer.
    always_ff @(posedge clk) begin
        // NOTE: every register here updates with <= so all of them sample the
        // pre-edge values; blocking = would leak new state into later lines.
        if (rst) begin
            r_state    <= IDLE;
            r_prio     <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r0_valid && (!r1_valid || !r_prio)) begin
                        r_state <= GNT0;
                    end else if (r1_valid) begin
                        r_state <= GNT1;
                    end
                end
                GNT0, GNT1: begin
                    if (w_release) begin
                        r_beat_cnt <= '0;
                        r_prio     <= (r_state == GNT0);
                        if (w_other_valid) begin
                            r_state <= w_other_state;   // zero-bubble switch
                        end else if (!w_last) begin
                            // Cap release with nobody waiting: the owner's
                            // valid was high (it just had a beat accepted),
                            // so it keeps the port for its next beats.
                            r_state <= r_state;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if (w_acc) begin
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Registered BRAM write port and out-of-range drop flag.
    always_ff @(posedge clk) begin
        // NOTE: the address/data registers are reset as well, because all
        // outputs must read 0 during reset, not just the enables.
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_err_oob <= 1'b0;
        end else begin
            r_wr_en   <= w_acc && !w_oob;
            r_err_oob <= w_acc && w_oob;
            if (w_acc && !w_oob) begin
                r_wr_addr <= w_addr;
                r_wr_data <= w_data;
            end
        end
    end

`ifdef FBUF_ARB_STATS_EN
    logic [31:0] r_stat_beats0;
    logic [31:0] r_stat_beats1;
    logic [31:0] r_stat_switches;

    assign stat_beats0   = r_stat_beats0;
    assign stat_beats1   = r_stat_beats1;
    assign stat_switches = r_stat_switches;

    // Saturating statistics; clear has priority over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            r_stat_beats0   <= '0;
            r_stat_beats1   <= '0;
            r_stat_switches <= '0;
        end else begin
            if (w_acc0 && (r_stat_beats0 != '1)) begin
                r_stat_beats0 <= r_stat_beats0 + 32'd1;
            end
            if (w_acc1 && (r_stat_beats1 != '1)) begin
                r_stat_beats1 <= r_stat_beats1 + 32'd1;
            end
            if (w_release && w_other_valid && (r_stat_switches != '1)) begin
                r_stat_switches <= r_stat_switches + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fbuf_write_arbiter.sv
// Testbench for fbuf_write_arbiter (MAX_BURST = 4).
// Cycle table: each record holds the inputs for one cycle and the outputs
// expected just after the following rising edge. Hand-written sequences
// then cover an out-of-range burst and, with FBUF_ARB_STATS_EN, stat_clr.
module tb_fbuf_write_arbiter;

    localparam int AW = 19;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          r0_valid, r0_ready, r0_last;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_data;
    logic          r1_valid, r1_ready, r1_last;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_data;
    logic          fbuf_en_wr, fbuf_wrea;
    logic [AW-1:0] fbuf_addr;
    logic [DW-1:0] fbuf_data;
    logic [1:0]    grant;
    logic          err_oob, busy;
`ifdef FBUF_ARB_STATS_EN
    logic          stat_clr;
    logic [31:0]   stat_beats0, stat_beats1, stat_switches;
`endif

    always #5 clk = ~clk;

    fbuf_write_arbiter #(
        .FBUF_ADDR_WIDTH(AW),
        .FBUF_DATA_WIDTH(DW),
        .FBUF_DEPTH     (307200),
        .MAX_BURST      (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .r0_valid     (r0_valid),
        .r0_ready     (r0_ready),
        .r0_last      (r0_last),
        .r0_addr      (r0_addr),
        .r0_data      (r0_data),
        .r1_valid     (r1_valid),
        .r1_ready     (r1_ready),
        .r1_last      (r1_last),
        .r1_addr      (r1_addr),
        .r1_data      (r1_data),
        .fbuf_en_wr   (fbuf_en_wr),
        .fbuf_wrea    (fbuf_wrea),
        .fbuf_addr    (fbuf_addr),
        .fbuf_data    (fbuf_data),
        .grant        (grant),
        .err_oob      (err_oob),
`ifdef FBUF_ARB_STATS_EN
        .stat_clr     (stat_clr),
        .stat_beats0  (stat_beats0),
        .stat_beats1  (stat_beats1),
        .stat_switches(stat_switches),
`endif
        .busy         (busy)
    );

    typedef struct {
        logic          rst;
        logic          v0, l0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          v1, l1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic [1:0]    gnt;
        logic          en;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          err;
        logic          chk_stat;
        int            b0, b1, sw;
    } vec_t;

    vec_t tbl [0:127];
    int   n_vec    = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input int rs, v0, l0, a0, d0, v1, l1, a1, d1,
                       gnt, en, addr, data, err);
        vec_t v;
        v.rst = (rs != 0);
        v.v0 = (v0 != 0);  v.l0 = (l0 != 0);  v.a0 = AW'(a0);  v.d0 = DW'(d0);
        v.v1 = (v1 != 0);  v.l1 = (l1 != 0);  v.a1 = AW'(a1);  v.d1 = DW'(d1);
        v.gnt  = 2'(gnt);
        v.en   = (en != 0);
        v.addr = AW'(addr);
        v.data = DW'(data);
        v.err  = (err != 0);
        v.chk_stat = 1'b0;
        v.b0 = 0;  v.b1 = 0;  v.sw = 0;
        tbl[n_vec] = v;
        n_vec++;
    endtask

    // Attach expected statistics to the most recently added record.
    task automatic add_stat(input int b0, input int b1, input int sw);
        tbl[n_vec-1].chk_stat = 1'b1;
        tbl[n_vec-1].b0 = b0;
        tbl[n_vec-1].b1 = b1;
        tbl[n_vec-1].sw = sw;
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst;
        r0_valid = v.v0;  r0_last = v.l0;  r0_addr = v.a0;  r0_data = v.d0;
        r1_valid = v.v1;  r1_last = v.l1;  r1_addr = v.a1;  r1_data = v.d1;
    endtask

    task automatic build_table();
        // Reset held 3 cycles with both requesters valid.
        for (int k = 0; k < 3; k++)
            add(1, 1,1,'h100,'h11, 1,1,'h200,'h22, 'b00,0,0,0,0);
        add(0, 1,1,'h100,'h11, 1,1,'h200,'h22, 'b01,0,0,0,0);
        add(0, 1,1,'h100,'h11, 1,1,'h200,'h22, 'b10,1,'h100,'h11,0);
        add(0, 0,0,0,0,        1,1,'h200,'h22, 'b00,1,'h200,'h22,0);
        add(0, 0,0,0,0,        0,0,0,0,        'b00,0,'h200,'h22,0);
        // Single req0 write from IDLE.
        add(0, 1,1,'h10,'hA5,  0,0,0,0,        'b01,0,'h200,'h22,0);
        add(0, 1,1,'h10,'hA5,  0,0,0,0,        'b00,1,'h10,'hA5,0);
        add(0, 0,0,0,0,        0,0,0,0,        'b00,0,'h10,'hA5,0);
        // Simultaneous 4-beat bursts after reset: req0 first, then req1.
        add(1, 0,0,0,0,        0,0,0,0,        'b00,0,0,0,0);
        add(0, 1,0,'h20,'h30,  1,0,'h40,'h50,  'b01,0,0,0,0);
        for (int i = 0; i < 4; i++)
            add(0, 1,(i==3),'h20+i,'h30+i, 1,0,'h40,'h50,
                (i==3) ? 'b10 : 'b01, 1,'h20+i,'h30+i,0);
        for (int j = 0; j < 4; j++)
            add(0, 0,0,0,0, 1,(j==3),'h40+j,'h50+j,
                (j==3) ? 'b00 : 'b10, 1,'h40+j,'h50+j,0);
        add(0, 0,0,0,0,        0,0,0,0,        'b00,0,'h43,'h53,0);
        add_stat(4, 4, 1);
        // Beat cap: req0 8 beats, req1 2 beats pending.
        add(0, 1,0,'h60,'h70,  1,0,'h80,'h90,  'b01,0,'h43,'h53,0);
        for (int i = 0; i < 4; i++)
            add(0, 1,0,'h60+i,'h70+i, 1,0,'h80,'h90,
                (i==3) ? 'b10 : 'b01, 1,'h60+i,'h70+i,0);
        for (int j = 0; j < 2; j++)
            add(0, 1,0,'h64,'h74, 1,(j==1),'h80+j,'h90+j,
                (j==1) ? 'b01 : 'b10, 1,'h80+j,'h90+j,0);
        for (int i = 4; i < 8; i++)
            add(0, 1,(i==7),'h60+i,'h70+i, 0,0,0,0,
                (i==7) ? 'b00 : 'b01, 1,'h60+i,'h70+i,0);
        add(0, 0,0,0,0,        0,0,0,0,        'b00,0,'h67,'h77,0);
        // Cap reached with nobody else waiting: owner keeps the port.
        add(0, 1,0,'hA0,'hB0,  0,0,0,0,        'b01,0,'h67,'h77,0);
        for (int i = 0; i < 5; i++)
            add(0, 1,(i==4),'hA0+i,'hB0+i, 0,0,0,0,
                (i==4) ? 'b00 : 'b01, 1,'hA0+i,'hB0+i,0);
        // Out-of-range single beat at 307200, then last valid address.
        add(1, 0,0,0,0,        0,0,0,0,        'b00,0,0,0,0);
        add(0, 0,0,0,0,        1,1,307200,'hEE, 'b10,0,0,0,0);
        add(0, 0,0,0,0,        1,1,307200,'hEE, 'b00,0,0,0,1);
        add_stat(0, 1, 0);
        add(0, 0,0,0,0,        0,0,0,0,        'b00,0,0,0,0);
        add(0, 0,0,0,0,        1,1,307199,'hEF, 'b10,0,0,0,0);
        add(0, 0,0,0,0,        1,1,307199,'hEF, 'b00,1,307199,'hEF,0);
        add(0, 0,0,0,0,        0,0,0,0,        'b00,0,307199,'hEF,0);
        // Reset in the middle of a req1 burst; fresh req0 served first.
        add(0, 0,0,0,0,        1,0,'hC0,'hD0,  'b10,0,307199,'hEF,0);
        for (int i = 0; i < 3; i++)
            add(0, 0,0,0,0, 1,0,'hC0+i,'hD0+i, 'b10,1,'hC0+i,'hD0+i,0);
        add(1, 1,1,'hE0,'hF0,  1,0,'hC3,'hD3,  'b00,0,0,0,0);
        add(0, 1,1,'hE0,'hF0,  1,0,'hC3,'hD3,  'b01,0,0,0,0);
        add(0, 1,1,'hE0,'hF0,  1,1,'hC3,'hD3,  'b10,1,'hE0,'hF0,0);
        add(0, 0,0,0,0,        1,1,'hC3,'hD3,  'b00,1,'hC3,'hD3,0);
        add(0, 0,0,0,0,        0,0,0,0,        'b00,0,'hC3,'hD3,0);
        // Burst lock: req0 pauses mid-burst, req1 must keep waiting.
        add(0, 1,0,'h11,'h22,  1,1,'h33,'h44,  'b01,0,'hC3,'hD3,0);
        add(0, 1,0,'h11,'h22,  1,1,'h33,'h44,  'b01,1,'h11,'h22,0);
        add(0, 0,0,0,0,        1,1,'h33,'h44,  'b01,0,'h11,'h22,0);
        add(0, 0,0,0,0,        1,1,'h33,'h44,  'b01,0,'h11,'h22,0);
        add(0, 1,1,'h12,'h23,  1,1,'h33,'h44,  'b10,1,'h12,'h23,0);
        add(0, 0,0,0,0,        1,1,'h33,'h44,  'b00,1,'h33,'h44,0);
        // Tie from IDLE while the pointer favours req1.
        add(0, 1,1,'h55,'h66,  0,0,0,0,        'b01,0,'h33,'h44,0);
        add(0, 1,1,'h55,'h66,  0,0,0,0,        'b00,1,'h55,'h66,0);
        add(0, 1,1,'h57,'h67,  1,1,'h58,'h68,  'b10,0,'h55,'h66,0);
        add(0, 1,1,'h57,'h67,  1,1,'h58,'h68,  'b01,1,'h58,'h68,0);
        add(0, 1,1,'h57,'h67,  0,0,0,0,        'b00,1,'h57,'h67,0);
        add(0, 0,0,0,0,        0,0,0,0,        'b00,0,'h57,'h67,0);
    endtask

    // Hard stop in case the bench itself gets stuck.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int waited, n_err, n_wr;
        rst = 1'b1;
        r0_valid = 1'b0;  r0_last = 1'b0;  r0_addr = '0;  r0_data = '0;
        r1_valid = 1'b0;  r1_last = 1'b0;  r1_addr = '0;  r1_data = '0;
`ifdef FBUF_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        build_table();

        for (int i = 0; i < n_vec; i++) begin
            drive(tbl[i]);
            @(posedge clk);
            #1;
            check($sformatf("row%0d grant", i), 64'(grant), 64'(tbl[i].gnt));
            check($sformatf("row%0d ready/busy", i),
                  64'({r1_ready, r0_ready, busy}),
                  64'({tbl[i].gnt[1], tbl[i].gnt[0], |tbl[i].gnt}));
            check($sformatf("row%0d en/wrea", i),
                  64'({fbuf_en_wr, fbuf_wrea}), 64'({tbl[i].en, tbl[i].en}));
            check($sformatf("row%0d addr", i), 64'(fbuf_addr), 64'(tbl[i].addr));
            check($sformatf("row%0d data", i), 64'(fbuf_data), 64'(tbl[i].data));
            check($sformatf("row%0d err_oob", i), 64'(err_oob), 64'(tbl[i].err));
`ifdef FBUF_ARB_STATS_EN
            if (tbl[i].chk_stat) begin
                check($sformatf("row%0d stat_beats0", i), 64'(stat_beats0), 64'(tbl[i].b0));
                check($sformatf("row%0d stat_beats1", i), 64'(stat_beats1), 64'(tbl[i].b1));
                check($sformatf("row%0d stat_switches", i), 64'(stat_switches), 64'(tbl[i].sw));
            end
`endif
        end

        // Back-to-back out-of-range burst: three err pulses, no writes.
        rst = 1'b1;
        r0_valid = 1'b0;  r1_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        r1_valid = 1'b1;  r1_addr = 19'h7FFFF;  r1_data = 8'h5A;  r1_last = 1'b0;
        waited = 0;
        while (!r1_ready && waited < 4) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("oob burst grant", 64'(r1_ready), 64'(1));
        n_err = 0;
        n_wr  = 0;
        for (int b = 0; b < 3; b++) begin
            r1_last = (b == 2);
            @(posedge clk);
            #1;
            n_err += int'(err_oob);
            n_wr  += int'(fbuf_en_wr);
        end
        r1_valid = 1'b0;
        r1_last  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            n_err += int'(err_oob);
            n_wr  += int'(fbuf_en_wr);
        end
        check("oob burst err pulses", 64'(n_err), 64'(3));
        check("oob burst writes", 64'(n_wr), 64'(0));
        check("oob burst final grant", 64'(grant), 64'(0));
`ifdef FBUF_ARB_STATS_EN
        check("oob burst stat_beats1", 64'(stat_beats1), 64'(3));
        // stat_clr in the same cycle as an accepted req0 beat wins.
        r0_valid = 1'b1;  r0_last = 1'b1;  r0_addr = 19'h5;  r0_data = 8'h77;
        @(posedge clk);
        #1;
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        r0_valid = 1'b0;
        check("stat_clr beats0", 64'(stat_beats0), 64'(0));
        check("stat_clr beats1", 64'(stat_beats1), 64'(0));
        @(posedge clk);
        #1;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
